// File: rtl/game_undo_stack.sv
// game_undo_stack: LIFO history of accepted player moves and the inverse move
// transform. On an undo the newest {box, dir} entry is popped and the previous
// game_state is rebuilt by walking the man back and pulling a pushed box back.
//
// Handshake semantics: there is no back-pressure. rec_valid and undo_req are
// single-cycle requests that are always taken on the clock edge where they
// are sampled, with the priority clear > rec_valid > undo_req. An accepted
// undo_req is answered exactly one cycle later by a one-cycle undo_done pulse
// (game_state_prev valid) or a one-cycle undo_fail pulse (history empty).
// A request that loses on priority gets no answer.
module game_undo_stack #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               rec_valid,
  input  logic [1:0]         rec_dir,
  input  logic               rec_box,
  input  logic               undo_req,
  input  logic [133:0]       game_state,
  output logic [133:0]       game_state_prev,
  output logic               undo_done,
  output logic               undo_fail,
  output logic [PTR_W:0]     count,
  output logic               empty,
  output logic               full
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Ring of {box, dir} entries; the top of the stack sits at wr_ptr-1.
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [2:0]       top_entry;

  // Reverse-transform working signals.
  logic [63:0]      way_in;
  logic [63:0]      box_in;
  logic [2:0]       m_x;
  logic [2:0]       m_y;
  logic [2:0]       fwd_x;
  logic [2:0]       fwd_y;
  logic [2:0]       back_x;
  logic [2:0]       back_y;
  logic [5:0]       m_idx;
  logic [5:0]       fwd_idx;
  logic [63:0]      way_rev;
  logic [63:0]      box_rev;
  logic [133:0]     rev_state;

  logic             do_clear;
  logic             do_record;
  logic             do_undo;

  assign top_ptr   = wr_ptr - PTR_W'(1);
  assign top_entry = mem[top_ptr];

  assign do_clear  = clear;
  assign do_record = !clear && rec_valid;
  assign do_undo   = !clear && !rec_valid && undo_req;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Inverse move: man steps back against dir; a pushed box moves from the
  // cell ahead of the man (M+d) back onto the man's current cell (M).
  always_comb begin
    way_in  = game_state[133:70];
    box_in  = game_state[69:6];
    m_x     = game_state[2:0];
    m_y     = game_state[5:3];
    fwd_x   = m_x;
    fwd_y   = m_y;
    back_x  = m_x;
    back_y  = m_y;
    case (top_entry[1:0])
      DIR_UP: begin
        fwd_y  = m_y - 3'd1;
        back_y = m_y + 3'd1;
      end
      DIR_DOWN: begin
        fwd_y  = m_y + 3'd1;
        back_y = m_y - 3'd1;
      end
      DIR_LEFT: begin
        fwd_x  = m_x - 3'd1;
        back_x = m_x + 3'd1;
      end
      DIR_RIGHT: begin
        fwd_x  = m_x + 3'd1;
        back_x = m_x - 3'd1;
      end
      default: ;
    endcase
    m_idx   = {m_y, m_x};
    fwd_idx = {fwd_y, fwd_x};
    way_rev = way_in;
    box_rev = box_in;
    if (top_entry[2]) begin
      box_rev[fwd_idx] = 1'b0;
      box_rev[m_idx]   = 1'b1;
      way_rev[fwd_idx] = 1'b1;
      way_rev[m_idx]   = 1'b0;
    end
    rev_state = {way_rev, box_rev, back_y, back_x};
  end

  // History storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (do_record) begin
      mem[wr_ptr] <= {rec_box, rec_dir};
    end
  end

  // Pointer, occupancy and undo result registers with prioritised commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      count           <= '0;
      game_state_prev <= '0;
      undo_done       <= 1'b0;
      undo_fail       <= 1'b0;
    end else begin
      undo_done <= 1'b0;
      undo_fail <= 1'b0;
      if (do_clear) begin
        wr_ptr <= '0;
        count  <= '0;
      end else if (do_record) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (count != DEPTH_C) begin
          count <= count + (PTR_W+1)'(1);
        end
      end else if (do_undo) begin
        if (count != '0) begin
          wr_ptr          <= top_ptr;
          count           <= count - (PTR_W+1)'(1);
          game_state_prev <= rev_state;
          undo_done       <= 1'b1;
        end else begin
          undo_fail <= 1'b1;
        end
      end
    end
  end

endmodule
